// File: rtl/pipeline_pkg.sv
// Shared definitions for the ID-stage hazard/forwarding control:
// FSM state encoding, operand-select codes and the forward-priority helper.
package pipeline_pkg;

    localparam int REG_W  = 5;
    localparam int WAIT_W = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Youngest producer wins: EX over MEM over WB.
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit,
                                            input logic wb_hit);
        if (ex_hit)       return FWD_EX;
        else if (mem_hit) return FWD_MEM;
        else if (wb_hit)  return FWD_WB;
        else              return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Purely combinational ID-stage match logic: operand forward selects and the
// number of stall cycles the instruction in ID requires (0 = no hazard).
module hazard_fwd_unit #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic [REG_W-1:0] ex_rw,
    input  logic             ex_regwr,
    input  logic             ex_load,
    input  logic [REG_W-1:0] mem_rw,
    input  logic             mem_regwr,
    input  logic             mem_load,
    input  logic [REG_W-1:0] wb_rw,
    input  logic             wb_regwr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             hazard,
    output logic [1:0]       stall_req
);
    import pipeline_pkg::*;

    logic rs_nz, rt_nz;
    logic ex_wr, mem_wr;
    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
    logic ex_use, mem_use;
    logic ld_use, br_ex_ld, br_ex_alu, br_mem_ld;

    // A load always writes its destination, even if regwr is not raised with it.
    assign ex_wr  = ex_regwr | ex_load;
    assign mem_wr = mem_regwr | mem_load;

    assign rs_nz = |id_rs;
    assign rt_nz = |id_rt;

    assign ex_hit_rs  = rs_nz && ex_wr    && (ex_rw  == id_rs);
    assign ex_hit_rt  = rt_nz && ex_wr    && (ex_rw  == id_rt);
    assign mem_hit_rs = rs_nz && mem_wr   && (mem_rw == id_rs);
    assign mem_hit_rt = rt_nz && mem_wr   && (mem_rw == id_rt);
    assign wb_hit_rs  = rs_nz && wb_regwr && (wb_rw  == id_rs);
    assign wb_hit_rt  = rt_nz && wb_regwr && (wb_rw  == id_rt);

    // A load in EX has no result yet, so it is never a forwarding source.
    assign fwd_a = fwd_pick(ex_hit_rs && !ex_load, mem_hit_rs, wb_hit_rs);
    assign fwd_b = fwd_pick(ex_hit_rt && !ex_load, mem_hit_rt, wb_hit_rt);

    assign ex_use  = (ex_hit_rs  && id_use_rs) || (ex_hit_rt  && id_use_rt);
    assign mem_use = (mem_hit_rs && id_use_rs) || (mem_hit_rt && id_use_rt);

    assign ld_use    = ex_load && ex_use;
    assign br_ex_ld  = id_branch && ex_load && ex_use;
    assign br_ex_alu = id_branch && !ex_load && ex_use;
    assign br_mem_ld = id_branch && mem_load && mem_use;

    always_comb begin
        stall_req = 2'd0;
        if (br_ex_ld)
            stall_req = 2'd2;
        else if (ld_use || br_ex_alu || br_mem_ld)
            stall_req = 2'd1;
    end

    assign hazard = |stall_req;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// IF/ID and ID/EX sequencing: RUN/STALL/FLUSH FSM with zero-latency stall
// entry, ID operand forward selects and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             id_taken,
    input  logic [REG_W-1:0] ex_rw,
    input  logic             ex_regwr,
    input  logic             ex_load,
    input  logic [REG_W-1:0] mem_rw,
    input  logic             mem_regwr,
    input  logic             mem_load,
    input  logic [REG_W-1:0] wb_rw,
    input  logic             wb_regwr,
    output logic             pc_ld,
    output logic             if_id_ld,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);
    import pipeline_pkg::*;

    hz_state_e         state, state_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic              hazard;
    logic [1:0]        stall_req;
    logic              eval;

    hazard_fwd_unit #(.REG_W(REG_W)) u_hfu (
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_branch (id_branch),
        .ex_rw     (ex_rw),
        .ex_regwr  (ex_regwr),
        .ex_load   (ex_load),
        .mem_rw    (mem_rw),
        .mem_regwr (mem_regwr),
        .mem_load  (mem_load),
        .wb_rw     (wb_rw),
        .wb_regwr  (wb_regwr),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .hazard    (hazard),
        .stall_req (stall_req)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
        end
    end

    // The cycle a hazard is seen is the first bubble; STALL covers the rest,
    // and once the wait count is exhausted the ID instruction is re-judged.
    always_comb begin
        state_n      = state;
        wait_n       = wait_cnt;
        pc_ld        = 1'b1;
        if_id_ld     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        eval         = 1'b0;

        case (state)
            RUN: eval = 1'b1;
            STALL: begin
                if (wait_cnt != '0) begin
                    pc_ld        = 1'b0;
                    if_id_ld     = 1'b0;
                    id_ex_bubble = 1'b1;
                    wait_n       = wait_cnt - 1'b1;
                end else begin
                    eval = 1'b1;
                end
            end
            FLUSH: begin
                if_id_flush = 1'b1;
                state_n     = RUN;
            end
            default: state_n = RUN;
        endcase

        if (eval) begin
            if (hazard) begin
                pc_ld        = 1'b0;
                if_id_ld     = 1'b0;
                id_ex_bubble = 1'b1;
                state_n      = STALL;
                wait_n       = stall_req - 2'd1;
            end else if (id_branch && id_taken) begin
                state_n = FLUSH;
            end else begin
                state_n = RUN;
            end
        end

        // Held in reset the pipeline free-runs regardless of the ID contents.
        if (!reset) begin
            pc_ld        = 1'b1;
            if_id_ld     = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (id_ex_bubble && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (if_id_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=4 build): inputs change on the
// falling edge, outputs are sampled 1 ns later, well before the next rising edge.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;

    logic             clk;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rw, mem_rw, wb_rw;
    logic             id_use_rs, id_use_rt, id_branch, id_taken;
    logic             ex_regwr, ex_load, mem_regwr, mem_load, wb_regwr;
    logic             pc_ld, if_id_ld, if_id_flush, id_ex_bubble;
    logic [1:0]       fwd_a, fwd_b, dbg_state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_branch    (id_branch),
        .id_taken     (id_taken),
        .ex_rw        (ex_rw),
        .ex_regwr     (ex_regwr),
        .ex_load      (ex_load),
        .mem_rw       (mem_rw),
        .mem_regwr    (mem_regwr),
        .mem_load     (mem_load),
        .wb_rw        (wb_rw),
        .wb_regwr     (wb_regwr),
        .pc_ld        (pc_ld),
        .if_id_ld     (if_id_ld),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .dbg_state    (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_branch = 1'b0; id_taken = 1'b0;
        ex_rw = '0; ex_regwr = 1'b0; ex_load = 1'b0;
        mem_rw = '0; mem_regwr = 1'b0; mem_load = 1'b0;
        wb_rw = '0; wb_regwr = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic check_ctl(input string tag, input logic pc, input logic ifid,
                             input logic fl, input logic bub);
        #1;
        check_eq({tag, "_pc_ld"},    pc_ld,        pc);
        check_eq({tag, "_if_id_ld"}, if_id_ld,     ifid);
        check_eq({tag, "_flush"},    if_id_flush,  fl);
        check_eq({tag, "_bubble"},   id_ex_bubble, bub);
    endtask

    // load in EX, branch in ID reading rt: two-cycle stall
    task automatic drive_branch_load();
        clear_inputs();
        id_branch = 1'b1; id_taken = 1'b1; id_rt = 5'd7; id_use_rt = 1'b1;
        ex_load = 1'b1; ex_regwr = 1'b1; ex_rw = 5'd7;
    endtask

    initial begin
        // reset held low with clock running, hazard present on the inputs
        reset = 1'b0;
        clear_inputs();
        repeat (3) next_cycle();
        check_ctl("rst", 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("rst_stall_cnt", stall_cnt, 0);
        check_eq("rst_flush_cnt", flush_cnt, 0);
        id_rs = 5'd5; id_use_rs = 1'b1; ex_load = 1'b1; ex_regwr = 1'b1; ex_rw = 5'd5;
        check_ctl("rst_hz", 1'b1, 1'b1, 1'b0, 1'b0);
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        #1 check_eq("rel_state", dbg_state, S_RUN);

        // load-use: one bubble, then MEM forwarding
        next_cycle();
        id_rs = 5'd5; id_use_rs = 1'b1; ex_load = 1'b1; ex_regwr = 1'b1; ex_rw = 5'd5;
        check_ctl("lu1", 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("lu1_fwd_a", fwd_a, 2'b00);
        next_cycle();
        ex_load = 1'b0; ex_regwr = 1'b0; ex_rw = '0;
        mem_load = 1'b1; mem_regwr = 1'b1; mem_rw = 5'd5;
        check_ctl("lu2", 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("lu2_fwd_a", fwd_a, 2'b10);
        check_eq("lu2_stall_cnt", stall_cnt, 1);
        next_cycle();
        clear_inputs();
        #1 check_eq("lu3_state", dbg_state, S_RUN);
        check_eq("lu3_stall_cnt", stall_cnt, 1);

        // branch-load: two bubbles, decision cycle, then one flush cycle
        next_cycle();
        drive_branch_load();
        check_ctl("bl1", 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        ex_load = 1'b0; ex_regwr = 1'b0; ex_rw = '0;
        mem_load = 1'b1; mem_regwr = 1'b1; mem_rw = 5'd7;
        check_ctl("bl2", 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("bl2_state", dbg_state, S_STALL);
        next_cycle();
        mem_load = 1'b0; mem_regwr = 1'b0; mem_rw = '0;
        wb_regwr = 1'b1; wb_rw = 5'd7;
        check_ctl("bl3", 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("bl3_fwd_b", fwd_b, 2'b11);
        check_eq("bl3_stall_cnt", stall_cnt, 3);
        next_cycle();
        clear_inputs();
        check_ctl("bl4", 1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle();
        check_ctl("bl5", 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("bl5_flush_cnt", flush_cnt, 1);
        check_eq("bl5_state", dbg_state, S_RUN);

        // forwarding priority and register 0
        next_cycle();
        id_rs = 5'd3; id_use_rs = 1'b1; id_rt = 5'd4; id_use_rt = 1'b1;
        ex_regwr = 1'b1; ex_rw = 5'd3; mem_regwr = 1'b1; mem_rw = 5'd3;
        wb_regwr = 1'b1; wb_rw = 5'd3;
        #1 check_eq("fw_ex", fwd_a, 2'b01);
        check_eq("fw_ex_b", fwd_b, 2'b00);
        check_eq("fw_ex_bubble", id_ex_bubble, 1'b0);
        next_cycle();
        ex_regwr = 1'b0;
        #1 check_eq("fw_mem", fwd_a, 2'b10);
        next_cycle();
        mem_regwr = 1'b0;
        #1 check_eq("fw_wb", fwd_a, 2'b11);
        next_cycle();
        id_rs = 5'd0;
        wb_rw = 5'd0;
        #1 check_eq("fw_r0", fwd_a, 2'b00);
        next_cycle();
        clear_inputs();
        id_rs = 5'd0; id_use_rs = 1'b1; ex_load = 1'b1; ex_regwr = 1'b1; ex_rw = 5'd0;
        check_ctl("r0_hz", 1'b1, 1'b1, 1'b0, 1'b0);

        // continuous hazard: stall counter saturates
        next_cycle();
        clear_inputs();
        id_rs = 5'd9; id_use_rs = 1'b1; ex_load = 1'b1; ex_regwr = 1'b1; ex_rw = 5'd9;
        repeat ((1 << CNT_W) + 3) next_cycle();
        #1 check_eq("sat_stall_cnt", stall_cnt, 4'hF);
        check_eq("sat_bubble", id_ex_bubble, 1'b1);
        check_eq("sat_flush_cnt", flush_cnt, 1);
        next_cycle();
        clear_inputs();
        next_cycle();
        #1 check_eq("sat_hold", stall_cnt, 4'hF);
        check_eq("sat_state", dbg_state, S_RUN);

        // asynchronous reset in the middle of a branch-load stall
        next_cycle();
        drive_branch_load();
        #1 check_eq("ar1_bubble", id_ex_bubble, 1'b1);
        next_cycle();
        ex_load = 1'b0; ex_regwr = 1'b0; ex_rw = '0;
        mem_load = 1'b1; mem_regwr = 1'b1; mem_rw = 5'd7;
        #1 check_eq("ar2_state", dbg_state, S_STALL);
        check_eq("ar2_bubble", id_ex_bubble, 1'b1);
        #1 reset = 1'b0;
        check_ctl("ar_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("ar_state", dbg_state, S_RUN);
        check_eq("ar_stall_cnt", stall_cnt, 0);
        check_eq("ar_flush_cnt", flush_cnt, 0);
        next_cycle();
        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1 check_eq($sformatf("ar_noflush%0d", i), if_id_flush, 1'b0);
        end
        check_eq("ar_end_state", dbg_state, S_RUN);
        check_eq("ar_end_flush_cnt", flush_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
